// File: rtl/tensor_core_pkg.sv
// Shared definitions for the tensor core loader.
//   - default frame geometry (word pairs per frame, bits per word, idle gap)
//   - loader FSM state type
//   - counter width helpers
// No ports.
package tensor_core_pkg;

    localparam int WORDS_DEF      = 16;
    localparam int WIDTH_DEF      = 16;
    localparam int GAP_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        FILL,
        ARM,
        SHIFT,
        DONE
    } loader_state_t;

    // Bits needed to index n items (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int WORD_IDX_W_DEF = cnt_w(WORDS_DEF);
    localparam int POS_W_DEF      = cnt_w(WIDTH_DEF + GAP_CYCLES_DEF + 1);
    localparam int LEN_W_DEF      = $clog2(WORDS_DEF + 1);

endpackage

// File: rtl/tensor_core_loader_word_buf.sv
// loader_word_buf: WORDS x (2*WIDTH) register file holding one frame of
// {B, A} word pairs. Storage is deliberately not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   {B, A} pair to store
//   raddr  in   read index
//   rdata  out  {B, A} pair at raddr (combinational read)
module loader_word_buf
    import tensor_core_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [cnt_w(WORDS)-1:0]   waddr,
    input  logic [2*WIDTH-1:0]        wdata,
    input  logic [cnt_w(WORDS)-1:0]   raddr,
    output logic [2*WIDTH-1:0]        rdata
);

    logic [2*WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tensor_core_loader.sv
// tensor_core_loader: buffers one frame of A/B word pairs and replays it to
// the bit-serial tensor core as two lock-step LSB-first streams, WIDTH data
// bits per word followed by GAP_CYCLES idle cycles. The core is held in reset
// for one cycle before every frame.
//
// Optional build macro: LOADER_PINGPONG_EN (two banks, next frame loads while
// the current one shifts; back-to-back frames are separated by DONE+ARM).
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   in_valid/ready   pair handshake; in_a/in_b data, in_last ends a frame
//   serial_a/b       registered serial bits to the core
//   core_rst_n       registered active-low reset to the core
//   busy             frame arming or shifting
//   frame_done       one-cycle pulse after the last gap cycle
//   err_len          one-cycle pulse on a frame length mismatch
//
// state | meaning
// FILL  | accepting pairs into the write bank
// ARM   | one cycle, core held in reset
// SHIFT | streaming WORDS x (WIDTH + GAP_CYCLES) cycles
// DONE  | one cycle, frame_done pulse
module tensor_core_loader
    import tensor_core_pkg::*;
#(
    parameter int WORDS      = WORDS_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             serial_a,
    output logic             serial_b,
    output logic             core_rst_n,
    output logic             busy,
    output logic             frame_done,
    output logic             err_len
);

    localparam int WIDX_W   = cnt_w(WORDS);
    localparam int LEN_W    = $clog2(WORDS + 1);
    localparam int BIT_W    = cnt_w(WIDTH);
    localparam int POS_W    = cnt_w(WIDTH + GAP_CYCLES + 1);
    localparam int LAST_POS = WIDTH + GAP_CYCLES - 1;

    loader_state_t     state, state_n;
    logic [WIDX_W-1:0] word_cnt, word_n;
    logic [POS_W-1:0]  pos_cnt, pos_n;
    logic [WIDX_W-1:0] wr_idx;

    logic              xfer, xfer_final, len_err;
    logic              cur_ready, alt_ready;
    logic [2*WIDTH-1:0] rd_word;
    logic [LEN_W-1:0]  rd_len;
    logic [LEN_W-1:0]  new_len;

    logic [WIDTH-1:0]  rd_a, rd_b;
    logic [BIT_W-1:0]  bit_sel;
    logic              serial_a_d, serial_b_d;

    assign xfer       = in_valid && in_ready;
    assign xfer_final = xfer && (in_last || (wr_idx == WIDX_W'(WORDS - 1)));
    // Mismatch when in_last disagrees with "this is the WORDS-th pair":
    // early in_last, or a full frame without in_last.
    assign len_err    = xfer && (in_last != (wr_idx == WIDX_W'(WORDS - 1)));
    assign new_len    = LEN_W'(wr_idx) + LEN_W'(1);

`ifdef LOADER_PINGPONG_EN
    logic             wr_bank, rd_bank;
    logic [1:0]       bank_full;
    logic [LEN_W-1:0] bank_len [2];
    logic [2*WIDTH-1:0] rdata0, rdata1;

    loader_word_buf #(.WORDS(WORDS), .WIDTH(WIDTH)) u_buf0 (
        .clk   (clk),
        .we    (xfer && !wr_bank),
        .waddr (wr_idx),
        .wdata ({in_b, in_a}),
        .raddr (word_n),
        .rdata (rdata0)
    );

    loader_word_buf #(.WORDS(WORDS), .WIDTH(WIDTH)) u_buf1 (
        .clk   (clk),
        .we    (xfer && wr_bank),
        .waddr (wr_idx),
        .wdata ({in_b, in_a}),
        .raddr (word_n),
        .rdata (rdata1)
    );

    assign rd_word  = rd_bank ? rdata1 : rdata0;
    assign rd_len   = bank_len[rd_bank];
    assign in_ready = !bank_full[wr_bank];
    // A bank that completes in this very cycle counts as ready, so the
    // final-pair-to-ARM latency stays at one cycle.
    assign cur_ready = bank_full[rd_bank]  || (xfer_final && (wr_bank == rd_bank));
    assign alt_ready = bank_full[!rd_bank] || (xfer_final && (wr_bank != rd_bank));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            bank_full   <= 2'b00;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
        end else begin
            if (xfer_final) begin
                bank_full[wr_bank] <= 1'b1;
                bank_len[wr_bank]  <= new_len;
                wr_bank            <= !wr_bank;
            end
            // The write bank never equals the read bank while the latter is
            // full, so these two updates never touch the same entry.
            if (state == DONE) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= !rd_bank;
            end
        end
    end
`else
    logic [LEN_W-1:0] frame_len;

    loader_word_buf #(.WORDS(WORDS), .WIDTH(WIDTH)) u_buf0 (
        .clk   (clk),
        .we    (xfer),
        .waddr (wr_idx),
        .wdata ({in_b, in_a}),
        .raddr (word_n),
        .rdata (rd_word)
    );

    assign rd_len    = frame_len;
    assign in_ready  = (state == FILL);
    assign cur_ready = xfer_final;
    assign alt_ready = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_len <= '0;
        end else if (xfer_final) begin
            frame_len <= new_len;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
        end else if (xfer) begin
            wr_idx <= xfer_final ? '0 : wr_idx + WIDX_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        word_n  = word_cnt;
        pos_n   = pos_cnt;
        unique case (state)
            FILL: begin
                if (cur_ready) begin
                    state_n = ARM;
                end
            end
            ARM: begin
                state_n = SHIFT;
                word_n  = '0;
                pos_n   = '0;
            end
            SHIFT: begin
                if (pos_cnt == POS_W'(LAST_POS)) begin
                    pos_n = '0;
                    if (word_cnt == WIDX_W'(WORDS - 1)) begin
                        state_n = DONE;
                        word_n  = '0;
                    end else begin
                        word_n = word_cnt + WIDX_W'(1);
                    end
                end else begin
                    pos_n = pos_cnt + POS_W'(1);
                end
            end
            DONE: begin
                state_n = alt_ready ? ARM : FILL;
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    // Serial bits are computed for the position the next cycle will hold,
    // then registered; words beyond a short frame's length read as zero.
    assign rd_a    = rd_word[WIDTH-1:0];
    assign rd_b    = rd_word[2*WIDTH-1:WIDTH];
    assign bit_sel = pos_n[BIT_W-1:0];

    always_comb begin
        serial_a_d = 1'b0;
        serial_b_d = 1'b0;
        if ((state_n == SHIFT) && (int'(pos_n) < WIDTH) &&
            (int'(word_n) < int'(rd_len))) begin
            serial_a_d = rd_a[bit_sel];
            serial_b_d = rd_b[bit_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            word_cnt   <= '0;
            pos_cnt    <= '0;
            serial_a   <= 1'b0;
            serial_b   <= 1'b0;
            core_rst_n <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state    <= state_n;
            word_cnt <= word_n;
            pos_cnt  <= pos_n;
            serial_a <= serial_a_d;
            serial_b <= serial_b_d;
            err_len  <= len_err;
            // Released on entering SHIFT and left high after DONE so the
            // core can drain its results.
            if (state_n == ARM) begin
                core_rst_n <= 1'b0;
            end else if (state_n == SHIFT) begin
                core_rst_n <= 1'b1;
            end
        end
    end

    assign busy       = (state == ARM) || (state == SHIFT);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_tensor_core_loader.sv
module tb_tensor_core_loader;

    localparam int WORDS = 16;
    localparam int WIDTH = 16;
    localparam int GAP   = 1;
    localparam int WLEN  = WIDTH + GAP;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_last = 1'b0;
    logic             serial_a, serial_b, core_rst_n, busy, frame_done, err_len;

    int n_vec = 0;
    int n_err = 0;

    // Reference frames: words as written by the source, plus frame length.
    logic [WIDTH-1:0] mod_a [2][WORDS];
    logic [WIDTH-1:0] mod_b [2][WORDS];
    int               mod_len [2];

    tensor_core_loader #(.WORDS(WORDS), .WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .serial_a   (serial_a),
        .serial_b   (serial_b),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .frame_done (frame_done),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic send_pair(input int slot, input int idx, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic last, input int idle);
        logic rdy;
        bit   acc;
        logic exp_err;
        acc = 1'b0;
        in_valid = 1'b0;
        repeat (idle) @(negedge clk);
        in_a = a;
        in_b = b;
        in_last = last;
        in_valid = 1'b1;
        for (int t = 0; t < 2000 && !acc; t++) begin
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            acc = rdy;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("send_timeout", 0, 1);
        end else begin
            mod_a[slot][idx] = a;
            mod_b[slot][idx] = b;
            if (last || idx == WORDS - 1) mod_len[slot] = idx + 1;
            exp_err = (last && idx < WORDS - 1) || (!last && idx == WORDS - 1);
            check("err_len", err_len, exp_err);
        end
    endtask

    // Entered at the negedge of the ARM cycle; ends at the negedge of DONE.
    task automatic check_frame(input int slot, input bit junk);
        logic ea, eb;
        check("arm_core_rst_n", core_rst_n, 0);
        check("arm_busy", busy, 1);
        check("arm_serial", {serial_a, serial_b}, 0);
`ifndef LOADER_PINGPONG_EN
        check("arm_in_ready", in_ready, 0);
        if (junk) begin
            in_valid = 1'b1;
            in_a = WIDTH'($urandom);
            in_b = WIDTH'($urandom);
            in_last = 1'($urandom);
        end
`endif
        for (int w = 0; w < WORDS; w++) begin
            for (int k = 0; k < WLEN; k++) begin
                @(negedge clk);
                if (w == WORDS - 1 && k == WLEN - 1) in_valid = 1'b0;
                if (w < mod_len[slot] && k < WIDTH) begin
                    ea = mod_a[slot][w][k];
                    eb = mod_b[slot][w][k];
                end else begin
                    ea = 1'b0;
                    eb = 1'b0;
                end
                check("serial_a", serial_a, ea);
                check("serial_b", serial_b, eb);
                if (k == 0) begin
                    check("shift_core_rst_n", core_rst_n, 1);
                    check("shift_frame_done", frame_done, 0);
                    check("shift_busy", busy, 1);
                end
            end
        end
        @(negedge clk);
        check("done_pulse", frame_done, 1);
        check("done_busy", busy, 0);
        check("done_core_rst_n", core_rst_n, 1);
    endtask

    task automatic expect_idle();
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_frame_done", frame_done, 0);
        check("idle_serial", {serial_a, serial_b}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_serial", {serial_a, serial_b}, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_len", err_len, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_core_rst_n", core_rst_n, 0);

        // Walking-one A, all-ones B.
        for (int w = 0; w < WORDS; w++)
            send_pair(0, w, 16'h0001 << w, 16'hFFFF, w == WORDS - 1, 0);
        check_frame(0, 1'b0);
        expect_idle();

        // Random idle cycles between pairs, junk held on in_valid while busy.
        for (int w = 0; w < WORDS; w++)
            send_pair(1, w, WIDTH'(w), ~WIDTH'(w), w == WORDS - 1, $urandom_range(0, 3));
        check_frame(1, 1'b1);
        expect_idle();

        // Short frame: in_last on pair 3; stale buffer contents must not leak.
        for (int w = 0; w < 4; w++)
            send_pair(0, w, (w == 3) ? 16'hA5A5 : WIDTH'($urandom), WIDTH'($urandom),
                      w == 3, 0);
        check_frame(0, 1'b0);
        expect_idle();

        // Missing in_last.
        for (int w = 0; w < WORDS; w++)
            send_pair(1, w, WIDTH'($urandom), WIDTH'($urandom), 1'b0, $urandom_range(0, 1));
        check_frame(1, 1'b0);
        expect_idle();

        // Reset 100 cycles into SHIFT, then a clean frame.
        for (int w = 0; w < WORDS; w++)
            send_pair(0, w, WIDTH'($urandom), WIDTH'($urandom), w == WORDS - 1, 0);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_serial", {serial_a, serial_b}, 0);
        check("midrst_core_rst_n", core_rst_n, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int w = 0; w < WORDS; w++)
            send_pair(1, w, WIDTH'($urandom), WIDTH'($urandom), w == WORDS - 1, 0);
        check_frame(1, 1'b0);
        expect_idle();

`ifdef LOADER_PINGPONG_EN
        // Continuous 32-pair stream: second frame loads during the first shift
        // and follows with only DONE+ARM between them.
        fork
            begin
                for (int i = 0; i < 2 * WORDS; i++)
                    send_pair(i / WORDS, i % WORDS, WIDTH'($urandom), WIDTH'($urandom),
                              (i % WORDS) == WORDS - 1, 0);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 200 && !seen; t++) begin
                    @(negedge clk);
                    seen = busy;
                end
                check("pp_arm_seen", seen, 1);
                check_frame(0, 1'b0);
                @(negedge clk);
                check_frame(1, 1'b0);
            end
        join
        expect_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
